csi2_frame_ctrl: RTL and testbench
==================================

Name: csi2_frame_ctrl

Overview:
Frame-level sequencer for the CSI-2 receive path. It sits after the packet handler, on the recovered byte clock. It gates the D-PHY receiver enable at frame boundaries and tracks FS/LS/LE/FE short packets and long-packet lines on one selected virtual channel. It counts lines and payload bytes against configured geometry and reports per-frame completion and error status.

Parameters:
PIX_DT, 6'h2B, long-packet data type counted as a pixel line (default RAW10)
LINE_W, 16, width of the line and byte counters

Ports:
clk_i  in  1  byte clock from D-PHY slave
rst_n_i  in  1  asynchronous, active-low reset
enable_i  in  1  software receive enable
vc_sel_i  in  2  virtual channel to track
exp_lines_i  in  LINE_W  expected pixel lines per frame
exp_word_cnt_i  in  16  expected long-packet word count (bytes)
short_pkt_valid_i  in  1  short packet strobe
short_pkt_v_channel_i  in  2  short packet VC
short_pkt_data_type_i  in  6  short packet DT
short_pkt_data_field_i  in  16  short packet data field (frame number on FS)
long_pkt_header_valid_i  in  1  long header strobe
long_pkt_v_channel_i  in  2  long header VC
long_pkt_data_type_i  in  6  long header DT
long_pkt_word_cnt_i  in  16  long header word count
long_pkt_payload_valid_i  in  1  payload beat strobe
long_pkt_payload_be_i  in  4  payload byte enables
header_error_i  in  1  ECC error detected
header_error_corrected_i  in  1  ECC error corrected
rx_enable_o  out  1  enable to D-PHY slave
frame_active_o  out  1  high from accepted FS to FE
payload_keep_o  out  1  combinational: long_pkt_payload_valid_i and state==IN_LINE
line_start_o  out  1  pulse, pixel line header accepted
line_end_o  out  1  pulse, last byte of line received
frame_done_o  out  1  pulse, FE closed a frame
frame_err_o  out  1  pulse with frame_done_o if any error flag is set
err_flags_o  out  5  flags of last closed frame
frame_num_o  out  16  frame number latched at FS
line_cnt_o  out  LINE_W  lines completed in the current frame

Behaviour:
- Reset: all outputs 0, state IDLE. All outputs except payload_keep_o are registered with 1-cycle latency.
- Events count only when the VC equals vc_sel_i. Short DTs: FS=0x00, FE=0x01, LS=0x02, LE=0x03. LS and LE are accepted and ignored.
- States:
  - IDLE: rx_enable_o=0. Goes to WAIT_FS when enable_i=1.
  - WAIT_FS: rx_enable_o=1. Goes to IDLE when enable_i=0. On FS: latch frame_num, clear line_cnt and the internal error accumulator, set frame_active_o, go to IN_FRAME.
  - IN_FRAME: on long header with DT==PIX_DT, latch word count, clear byte counter, pulse line_start_o, go to IN_LINE. Set err[1] (WC) if word count != exp_word_cnt_i. Other DTs are ignored.
  - IN_LINE: on each payload beat, byte_cnt += popcount(be) (3-bit). When byte_cnt+popcount >= latched word count: pulse line_end_o, line_cnt+1, go to IN_FRAME.
  - DROP: ignores everything except FE and FS.
- Uncorrectable ECC (header_error_i and not header_error_corrected_i) in IN_FRAME or IN_LINE: set err[0], go to DROP.
- FE in IN_FRAME, IN_LINE or DROP:
  - Set err[4] if in IN_LINE (truncated line).
  - Set err[2] if line_cnt (including a line finishing this cycle) != exp_lines_i.
  - Pulse frame_done_o; pulse frame_err_o if any flag is set; load err_flags_o; clear frame_active_o.
  - Next state: WAIT_FS if enable_i=1, else IDLE.
- FS while a frame is open: close the old frame as for FE, with err[3] added, in the same cycle. Then start the new frame immediately, without passing through WAIT_FS.
- enable_i=0 mid-frame: the current frame finishes normally. rx_enable_o drops only on the IDLE transition.
- Counters saturate at all-ones and never wrap.
- Word count 0: the line completes on the header cycle. line_start_o and line_end_o pulse together; no IN_LINE visit.
- Simultaneous header and payload in the same cycle: the header is processed first.
- Asynchronous reset mid-frame returns to IDLE. No frame_done_o is generated.

Decomposition:
- csi2_pkg holds:
  - DT constants: DT_FS, DT_FE, DT_LS, DT_LE, DT_RAW8, DT_RAW10.
  - State enum: IDLE, WAIT_FS, IN_FRAME, IN_LINE, DROP.
  - Error bit indices: ERR_ECC=0, ERR_WC=1, ERR_LINES=2, ERR_FS_NO_FE=3, ERR_TRUNC=4.
- One sub-module, csi2_line_byte_cnt: byte-enable popcount plus the saturating byte accumulator with a done compare.

Test Plan:
- Nominal frame: enable_i=1, vc_sel_i=0, exp_lines_i=4, exp_word_cnt_i=8. Send FS(field=0x0007), 4 lines of DT 0x2B with WC=8 and 2 full-BE beats each, then FE. Expect 4 line_start_o/line_end_o pairs, line_cnt_o=4, frame_num_o=7, frame_done_o=1, frame_err_o=0, err_flags_o=0.
- Line count error: same frame with only 3 lines. Expect frame_done_o and frame_err_o together, err_flags_o=5'b00100.
- Partial BE: WC=6, beats with BE 4'hF then 4'h3. Expect line_end_o on the second beat. Other-VC and DT 0x12 packets are ignored: no payload_keep_o.
- Uncorrectable ECC mid-frame, then 2 more lines, then FE. Expect no line pulses after the error, err_flags_o bit0 set, one frame_done_o.
- FS with no FE, then a second FS. Expect frame_err_o with err[3] set, frame_active_o staying 1, frame_num_o updated to the second field.
- enable_i drop mid-frame: rx_enable_o stays 1 until FE, then 0 one cycle later. Async rst_n_i low mid-line gives all outputs 0 immediately.

Source files
------------

// File: rtl/csi2_pkg.sv
// csi2_pkg: shared constants, state encoding and helpers
// for the CSI-2 frame sequencer.
package csi2_pkg;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_LS    = 6'h02;
   localparam logic [5:0] DT_LE    = 6'h03;
   localparam logic [5:0] DT_RAW8  = 6'h2A;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FS,
      IN_FRAME,
      IN_LINE,
      DROP
   } state_e;

   localparam int ERR_ECC      = 0;
   localparam int ERR_WC       = 1;
   localparam int ERR_LINES    = 2;
   localparam int ERR_FS_NO_FE = 3;
   localparam int ERR_TRUNC    = 4;
   localparam int ERR_W        = 5;

   function automatic logic [2:0] popcnt4(input logic [3:0] be);
      return {2'b0, be[0]} + {2'b0, be[1]}
           + {2'b0, be[2]} + {2'b0, be[3]};
   endfunction

endpackage

// File: rtl/csi2_line_byte_cnt.sv
// csi2_line_byte_cnt: per-line payload byte accumulator.
// Ports: start_i latches wc_i and clears the count; beat_i/be_i
// add popcount(be); done_o flags the beat that reaches wc.
module csi2_line_byte_cnt
   import csi2_pkg::*;
#(
   parameter int W = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [15:0] wc_i,
   input  logic        beat_i,
   input  logic [3:0]  be_i,
   output logic        done_o
);

   localparam int CW = (W > 16) ? W : 16;

   logic [W-1:0] cnt_q;
   logic [15:0]  wc_q;
   logic [CW:0]  sum;

   // One spare bit so the compare and saturation see the carry.
   assign sum = (CW+1)'(cnt_q) + (CW+1)'(popcnt4(be_i));
   assign done_o = beat_i && (sum >= (CW+1)'(wc_q));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         wc_q  <= '0;
      end else if (start_i) begin
         cnt_q <= '0;
         wc_q  <= wc_i;
      end else if (beat_i) begin
         if (|(sum >> W)) cnt_q <= '1;
         else             cnt_q <= sum[W-1:0];
      end
   end

endmodule

// File: rtl/csi2_frame_ctrl.sv
// csi2_frame_ctrl: CSI-2 frame sequencer. Gates the D-PHY enable,
// tracks FS/FE and pixel lines on vc_sel_i, checks geometry.
// Inputs: short/long packet strobes, payload beats, ECC status,
// expected lines / word count. Outputs: rx_enable_o, frame and
// line pulses, err_flags_o, frame_num_o, line_cnt_o (registered);
// payload_keep_o (combinational).
module csi2_frame_ctrl
   import csi2_pkg::*;
#(
   parameter logic [5:0] PIX_DT = DT_RAW10,
   parameter int         LINE_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              enable_i,
   input  logic [1:0]        vc_sel_i,
   input  logic [LINE_W-1:0] exp_lines_i,
   input  logic [15:0]       exp_word_cnt_i,
   input  logic              short_pkt_valid_i,
   input  logic [1:0]        short_pkt_v_channel_i,
   input  logic [5:0]        short_pkt_data_type_i,
   input  logic [15:0]       short_pkt_data_field_i,
   input  logic              long_pkt_header_valid_i,
   input  logic [1:0]        long_pkt_v_channel_i,
   input  logic [5:0]        long_pkt_data_type_i,
   input  logic [15:0]       long_pkt_word_cnt_i,
   input  logic              long_pkt_payload_valid_i,
   input  logic [3:0]        long_pkt_payload_be_i,
   input  logic              header_error_i,
   input  logic              header_error_corrected_i,
   output logic              rx_enable_o,
   output logic              frame_active_o,
   output logic              payload_keep_o,
   output logic              line_start_o,
   output logic              line_end_o,
   output logic              frame_done_o,
   output logic              frame_err_o,
   output logic [ERR_W-1:0]  err_flags_o,
   output logic [15:0]       frame_num_o,
   output logic [LINE_W-1:0] line_cnt_o
);

   state_e state_q, state_d;

   logic [LINE_W-1:0] lcnt_d, lcnt_inc;
   logic [ERR_W-1:0]  acc_q, acc_d, flags_d, close_flags;
   logic [15:0]       fnum_d;
   logic act_d, ls_d, le_d, done_d, ferr_d;
   logic fs_ev, fe_ev, pix_hdr, ecc_bad;
   logic line_done, cnt_start, close, start_frame, fin;

   assign fs_ev = short_pkt_valid_i
               && short_pkt_v_channel_i == vc_sel_i
               && short_pkt_data_type_i == DT_FS;
   assign fe_ev = short_pkt_valid_i
               && short_pkt_v_channel_i == vc_sel_i
               && short_pkt_data_type_i == DT_FE;
   assign pix_hdr = long_pkt_header_valid_i
                 && long_pkt_v_channel_i == vc_sel_i
                 && long_pkt_data_type_i == PIX_DT;
   assign ecc_bad = header_error_i && !header_error_corrected_i;

   assign payload_keep_o = long_pkt_payload_valid_i
                        && state_q == IN_LINE;

   assign lcnt_inc = (&line_cnt_o) ? line_cnt_o
                   : line_cnt_o + LINE_W'(1);

   csi2_line_byte_cnt #(.W(LINE_W)) u_byte_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .start_i (cnt_start),
      .wc_i    (long_pkt_word_cnt_i),
      .beat_i  (payload_keep_o),
      .be_i    (long_pkt_payload_be_i),
      .done_o  (line_done)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      lcnt_d      = line_cnt_o;
      acc_d       = acc_q;
      flags_d     = err_flags_o;
      fnum_d      = frame_num_o;
      act_d       = frame_active_o;
      ls_d        = 1'b0;
      le_d        = 1'b0;
      done_d      = 1'b0;
      ferr_d      = 1'b0;
      cnt_start   = 1'b0;
      close       = 1'b0;
      start_frame = 1'b0;
      fin         = 1'b0;
      close_flags = acc_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i) state_d = WAIT_FS;
         end
         WAIT_FS: begin
            if (!enable_i)  state_d = IDLE;
            else if (fs_ev) start_frame = 1'b1;
         end
         IN_FRAME: begin
            if (ecc_bad) begin
               acc_d[ERR_ECC] = 1'b1;
               state_d = DROP;
            end else if (fs_ev || fe_ev) begin
               close = 1'b1;
            end else if (pix_hdr) begin
               ls_d = 1'b1;
               cnt_start = 1'b1;
               if (long_pkt_word_cnt_i != exp_word_cnt_i)
                  acc_d[ERR_WC] = 1'b1;
               // Empty line: done on the header itself.
               if (long_pkt_word_cnt_i == '0) begin
                  le_d = 1'b1;
                  lcnt_d = lcnt_inc;
               end else begin
                  state_d = IN_LINE;
               end
            end
         end
         IN_LINE: begin
            if (ecc_bad) begin
               acc_d[ERR_ECC] = 1'b1;
               state_d = DROP;
            end else begin
               fin = line_done;
               if (fin) begin
                  le_d = 1'b1;
                  lcnt_d = lcnt_inc;
                  state_d = IN_FRAME;
               end
               // A line finishing on the FE/FS cycle is not truncated.
               if (fs_ev || fe_ev) begin
                  close = 1'b1;
                  close_flags[ERR_TRUNC] = !fin;
               end
            end
         end
         DROP: begin
            if (fs_ev || fe_ev) close = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (close) begin
         if (lcnt_d != exp_lines_i)
            close_flags[ERR_LINES] = 1'b1;
         if (fs_ev)
            close_flags[ERR_FS_NO_FE] = 1'b1;
         flags_d = close_flags;
         done_d  = 1'b1;
         ferr_d  = |close_flags;
         act_d   = 1'b0;
         state_d = enable_i ? WAIT_FS : IDLE;
      end

      // FS on an open frame reopens straight away.
      if (start_frame || (close && fs_ev)) begin
         fnum_d  = short_pkt_data_field_i;
         lcnt_d  = '0;
         acc_d   = '0;
         act_d   = 1'b1;
         state_d = IN_FRAME;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_enable_o    <= 1'b0;
         frame_active_o <= 1'b0;
         line_start_o   <= 1'b0;
         line_end_o     <= 1'b0;
         frame_done_o   <= 1'b0;
         frame_err_o    <= 1'b0;
         err_flags_o    <= '0;
         frame_num_o    <= '0;
         line_cnt_o     <= '0;
         acc_q          <= '0;
      end else begin
         rx_enable_o    <= state_d != IDLE;
         frame_active_o <= act_d;
         line_start_o   <= ls_d;
         line_end_o     <= le_d;
         frame_done_o   <= done_d;
         frame_err_o    <= ferr_d;
         err_flags_o    <= flags_d;
         frame_num_o    <= fnum_d;
         line_cnt_o     <= lcnt_d;
         acc_q          <= acc_d;
      end
   end

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// tb_csi2_frame_ctrl: directed plus random frame traffic checked
// cycle by cycle against a packet-level model of the sequencer.
module tb_csi2_frame_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        en;
   logic [1:0]  vc_sel;
   logic [15:0] exp_lines, exp_wc;
   logic        spv, lhv, pv, herr, hcorr;
   logic [1:0]  svc, lvc;
   logic [5:0]  sdt, ldt;
   logic [15:0] sfield, lwc;
   logic [3:0]  be;

   logic        rx_enable_o, frame_active_o, payload_keep_o;
   logic        line_start_o, line_end_o, frame_done_o, frame_err_o;
   logic [4:0]  err_flags_o;
   logic [15:0] frame_num_o, line_cnt_o;

   csi2_frame_ctrl dut (
      .clk_i                    (clk),
      .rst_n_i                  (rst_n),
      .enable_i                 (en),
      .vc_sel_i                 (vc_sel),
      .exp_lines_i              (exp_lines),
      .exp_word_cnt_i           (exp_wc),
      .short_pkt_valid_i        (spv),
      .short_pkt_v_channel_i    (svc),
      .short_pkt_data_type_i    (sdt),
      .short_pkt_data_field_i   (sfield),
      .long_pkt_header_valid_i  (lhv),
      .long_pkt_v_channel_i     (lvc),
      .long_pkt_data_type_i     (ldt),
      .long_pkt_word_cnt_i      (lwc),
      .long_pkt_payload_valid_i (pv),
      .long_pkt_payload_be_i    (be),
      .header_error_i           (herr),
      .header_error_corrected_i (hcorr),
      .rx_enable_o              (rx_enable_o),
      .frame_active_o           (frame_active_o),
      .payload_keep_o           (payload_keep_o),
      .line_start_o             (line_start_o),
      .line_end_o               (line_end_o),
      .frame_done_o             (frame_done_o),
      .frame_err_o              (frame_err_o),
      .err_flags_o              (err_flags_o),
      .frame_num_o              (frame_num_o),
      .line_cnt_o               (line_cnt_o)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cnt_ls = 0, cnt_le = 0, cnt_done = 0;

   // Model: frame open / dropping / inside a line with bytes left.
   logic m_armed, m_open, m_drop, m_inline;
   int   m_left, m_lines;
   logic [4:0]  m_errs;
   logic [15:0] m_fnum;
   logic e_rx, e_act, e_ls, e_le, e_done, e_err;
   logic [4:0]  e_flags;
   logic [15:0] e_fnum, e_lcnt;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h @%0t",
                    name, act, exp, $time);
   endtask

   function automatic int pc(input logic [3:0] b);
      return int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
   endfunction

   task automatic model_reset();
      m_armed = 0; m_open = 0; m_drop = 0; m_inline = 0;
      m_left = 0; m_lines = 0; m_errs = '0; m_fnum = '0;
      e_rx = 0; e_act = 0; e_ls = 0; e_le = 0;
      e_done = 0; e_err = 0; e_flags = '0;
      e_fnum = '0; e_lcnt = '0;
   endtask

   task automatic open_frame();
      m_open = 1; m_drop = 0; m_inline = 0;
      m_fnum = sfield; m_lines = 0; m_errs = '0;
   endtask

   task automatic bump();
      if (m_lines < 65535) m_lines++;
   endtask

   task automatic model();
      logic fs, fe, lh, bad, fin, was_line;
      logic [4:0] fl;
      e_ls = 0; e_le = 0; e_done = 0; e_err = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      fs  = spv && svc == vc_sel && sdt == 6'h00;
      fe  = spv && svc == vc_sel && sdt == 6'h01;
      lh  = lhv && lvc == vc_sel && ldt == 6'h2B;
      bad = herr && !hcorr;
      if (!m_open) begin
         if (!m_armed)   m_armed = en;
         else if (!en)   m_armed = 0;
         else if (fs)    open_frame();
      end else if (bad && !m_drop) begin
         m_errs[0] = 1; m_drop = 1; m_inline = 0;
      end else begin
         was_line = m_inline;
         fin = 0;
         if (m_inline && pv) begin
            if (pc(be) >= m_left) begin
               fin = 1; m_inline = 0; e_le = 1; bump();
            end else begin
               m_left -= pc(be);
            end
         end
         if (fs || fe) begin
            fl = m_errs;
            if (was_line && !fin) fl[4] = 1;
            if (m_lines != int'(exp_lines)) fl[2] = 1;
            if (fs) fl[3] = 1;
            e_flags = fl; e_done = 1; e_err = (fl != 0);
            m_open = 0; m_drop = 0; m_inline = 0; m_armed = en;
            if (fs) open_frame();
         end else if (lh && !was_line && !m_drop) begin
            e_ls = 1;
            if (lwc != exp_wc) m_errs[1] = 1;
            if (lwc == 0) begin
               e_le = 1; bump();
            end else begin
               m_inline = 1; m_left = int'(lwc);
            end
         end
      end
      e_rx = m_armed || m_open;
      e_act = m_open;
      e_fnum = m_fnum;
      e_lcnt = 16'(m_lines);
   endtask

   // Model consumes this cycle's inputs at the edge; the bench
   // changes inputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic sp(input logic [1:0] v, input logic [5:0] dt,
                     input logic [15:0] f);
      spv = 1; svc = v; sdt = dt; sfield = f;
      step();
      spv = 0;
   endtask

   task automatic lh(input logic [1:0] v, input logic [5:0] dt,
                     input logic [15:0] wc);
      lhv = 1; lvc = v; ldt = dt; lwc = wc;
      step();
      lhv = 0;
   endtask

   task automatic bt(input logic [3:0] b);
      pv = 1; be = b;
      step();
      pv = 0;
   endtask

   task automatic ecc(input logic c);
      herr = 1; hcorr = c;
      step();
      herr = 0; hcorr = 0;
   endtask

   task automatic line8();
      lh(2'd0, 6'h2B, 16'd8);
      bt(4'hF);
      bt(4'hF);
   endtask

   function automatic logic [1:0] rvc();
      if ($urandom_range(0, 4) != 0) return vc_sel;
      return 2'($urandom_range(0, 3));
   endfunction

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("rx_enable", 32'(rx_enable_o), 32'(e_rx));
         chk("frame_active", 32'(frame_active_o), 32'(e_act));
         chk("line_start", 32'(line_start_o), 32'(e_ls));
         chk("line_end", 32'(line_end_o), 32'(e_le));
         chk("frame_done", 32'(frame_done_o), 32'(e_done));
         chk("frame_err", 32'(frame_err_o), 32'(e_err));
         chk("err_flags", 32'(err_flags_o), 32'(e_flags));
         chk("frame_num", 32'(frame_num_o), 32'(e_fnum));
         chk("line_cnt", 32'(line_cnt_o), 32'(e_lcnt));
         chk("payload_keep", 32'(payload_keep_o),
             32'(pv && m_inline));
         cnt_ls   += int'(line_start_o);
         cnt_le   += int'(line_end_o);
         cnt_done += int'(frame_done_o);
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int b_ls, b_le, b_done, r;
      rst_n = 0; en = 0; vc_sel = 0;
      exp_lines = 16'd4; exp_wc = 16'd8;
      spv = 0; lhv = 0; pv = 0; herr = 0; hcorr = 0;
      svc = 0; lvc = 0; sdt = 0; ldt = 0;
      sfield = 0; lwc = 0; be = 0;
      model_reset();
      idle(3);
      chk("rst_rx", 32'(rx_enable_o), 0);
      chk("rst_active", 32'(frame_active_o), 0);
      chk("rst_flags", 32'(err_flags_o), 0);
      chk("rst_lcnt", 32'(line_cnt_o), 0);
      rst_n = 1;
      idle(1);

      // Nominal frame.
      en = 1;
      idle(2);
      chk("nom_rx", 32'(rx_enable_o), 1);
      b_ls = cnt_ls; b_le = cnt_le;
      sp(2'd0, 6'h00, 16'h0007);
      chk("nom_active", 32'(frame_active_o), 1);
      chk("nom_fnum", 32'(frame_num_o), 32'h7);
      repeat (4) line8();
      sp(2'd0, 6'h01, 16'h0);
      chk("nom_done", 32'(frame_done_o), 1);
      chk("nom_err", 32'(frame_err_o), 0);
      chk("nom_flags", 32'(err_flags_o), 0);
      chk("nom_lcnt", 32'(line_cnt_o), 4);
      idle(1);
      chk("nom_ls_cnt", 32'(cnt_ls - b_ls), 4);
      chk("nom_le_cnt", 32'(cnt_le - b_le), 4);

      // Short frame: 3 lines against 4 expected.
      sp(2'd0, 6'h00, 16'h0008);
      repeat (3) line8();
      sp(2'd0, 6'h01, 16'h0);
      chk("lines_done", 32'(frame_done_o), 1);
      chk("lines_err", 32'(frame_err_o), 1);
      chk("lines_flags", 32'(err_flags_o), 32'b00100);
      idle(1);

      // Partial byte enables and ignored traffic.
      exp_wc = 16'd6; exp_lines = 16'd1;
      sp(2'd0, 6'h00, 16'h0020);
      lh(2'd0, 6'h2B, 16'd6);
      pv = 1; be = 4'hF; #1;
      chk("pbe_keep", 32'(payload_keep_o), 1);
      step(); pv = 0;
      bt(4'h3);
      chk("pbe_le", 32'(line_end_o), 1);
      lh(2'd1, 6'h2B, 16'd6);
      lh(2'd0, 6'h12, 16'd6);
      pv = 1; be = 4'hF; #1;
      chk("ign_keep", 32'(payload_keep_o), 0);
      step(); pv = 0;
      sp(2'd0, 6'h01, 16'h0);
      chk("pbe_flags", 32'(err_flags_o), 0);
      chk("pbe_lcnt", 32'(line_cnt_o), 1);
      idle(1);

      // Uncorrectable ECC mid-line, then lines into DROP.
      exp_wc = 16'd8; exp_lines = 16'd4;
      sp(2'd0, 6'h00, 16'h0030);
      line8();
      lh(2'd0, 6'h2B, 16'd8);
      bt(4'hF);
      ecc(1'b0);
      b_ls = cnt_ls; b_le = cnt_le; b_done = cnt_done;
      line8();
      line8();
      sp(2'd0, 6'h01, 16'h0);
      chk("ecc_flags", 32'(err_flags_o), 32'b00101);
      idle(1);
      chk("ecc_ls_cnt", 32'(cnt_ls - b_ls), 0);
      chk("ecc_le_cnt", 32'(cnt_le - b_le), 0);
      chk("ecc_done_cnt", 32'(cnt_done - b_done), 1);

      // FS without FE.
      sp(2'd0, 6'h00, 16'h0010);
      line8();
      sp(2'd0, 6'h00, 16'h0011);
      chk("fs2_err", 32'(frame_err_o), 1);
      chk("fs2_flags", 32'(err_flags_o), 32'b01100);
      chk("fs2_active", 32'(frame_active_o), 1);
      chk("fs2_fnum", 32'(frame_num_o), 32'h11);
      chk("fs2_lcnt", 32'(line_cnt_o), 0);
      sp(2'd0, 6'h01, 16'h0);
      idle(1);

      // Enable dropped mid-frame.
      sp(2'd0, 6'h00, 16'h0040);
      en = 0;
      idle(3);
      chk("endrop_rx_hold", 32'(rx_enable_o), 1);
      sp(2'd0, 6'h01, 16'h0);
      chk("endrop_rx_off", 32'(rx_enable_o), 0);
      chk("endrop_done", 32'(frame_done_o), 1);

      // Asynchronous reset in the middle of a line.
      en = 1;
      idle(2);
      sp(2'd0, 6'h00, 16'h0050);
      lh(2'd0, 6'h2B, 16'd8);
      bt(4'hF);
      pv = 1; be = 4'hF; rst_n = 0; #1;
      model_reset();
      chk("arst_rx", 32'(rx_enable_o), 0);
      chk("arst_active", 32'(frame_active_o), 0);
      chk("arst_keep", 32'(payload_keep_o), 0);
      chk("arst_lcnt", 32'(line_cnt_o), 0);
      chk("arst_fnum", 32'(frame_num_o), 0);
      pv = 0;
      idle(2);
      rst_n = 1;
      idle(1);

      // Random traffic.
      vc_sel = 2'd1; exp_lines = 16'd2; exp_wc = 16'd4;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         r = $urandom_range(0, 99);
         if (r < 3)
            sp(rvc(), 6'h00, 16'($urandom));
         else if (r < 6)
            sp(rvc(), 6'h01, 16'h0);
         else if (r < 8)
            sp(rvc(), 6'($urandom), 16'($urandom));
         else if (r < 18)
            lh(rvc(),
               ($urandom_range(0, 4) != 0) ? 6'h2B : 6'h12,
               ($urandom_range(0, 1) != 0) ? exp_wc
                  : 16'($urandom_range(0, 10)));
         else if (r < 20)
            ecc(1'($urandom_range(0, 1)));
         else if (r < 70)
            bt(4'($urandom));
         else
            idle(1);
      end

      en = 0;
      idle(4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
